// File: rtl/updown_counter_param.sv
// updown_counter_param: parametrised up/down counter with wrap or saturate at the bounds,
// clamped parallel load with a sticky range-error flag, and a registered terminal-count pulse.
module updown_counter_param #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_COUNT = 255,
   parameter bit          SATURATE  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             direction,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             clear_err,
   output logic [WIDTH-1:0] counter_out,
   output logic             tc,
   output logic             at_max,
   output logic             at_min,
   output logic             load_err
);
   localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_COUNT);
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             tc_q, tc_d, err_q, err_d, over;
   assign over = load_value > MAX;
   // the bound is tested before stepping, so the +1/-1 can never leave 0..MAX
   always_comb begin
      cnt_d = cnt_q;
      tc_d  = 1'b0;
      err_d = (err_q & ~clear_err) | (load & over);
      if (load)
         cnt_d = over ? MAX : load_value;
      else if (enable & direction) begin
         tc_d  = cnt_q >= MAX;
         cnt_d = !tc_d ? cnt_q + 1'b1 : SATURATE ? MAX : '0;
      end else if (enable) begin
         tc_d  = cnt_q == '0;
         cnt_d = !tc_d ? cnt_q - 1'b1 : SATURATE ? '0 : MAX;
      end
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         cnt_q <= '0;
         tc_q  <= 1'b0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tc_q  <= tc_d;
         err_q <= err_d;
      end
   assign counter_out = cnt_q;
   assign tc          = tc_q;
   assign load_err    = err_q;
   assign at_max      = cnt_q == MAX;
   assign at_min      = cnt_q == '0;
endmodule

// File: tb/tb_updown_counter_param.sv
// tb_updown_counter_param: three instances (8/255 wrap, 4/9 wrap, 4/9 saturate) driven in
// lockstep and compared each cycle against an arithmetic reference model.
module tb_updown_counter_param;
   logic clk = 1'b0, rst = 1'b0, enable = 1'b0, direction = 1'b0, load = 1'b0, clear_err = 1'b0;
   logic [7:0] lv = '0;
   logic [7:0] c8;
   logic [3:0] cw, cs;
   logic [2:0] tc_o, mx_o, mn_o, er_o;
   logic [11:0] obs [3];
   int errors = 0, checks = 0;
   int m_cnt [3];
   bit m_tc [3], m_err [3];
   int mx_a [3]   = '{255, 9, 9};
   int mask_a [3] = '{255, 15, 15};
   bit sat_a [3]  = '{1'b0, 1'b0, 1'b1};

   always #5 clk = ~clk;

   updown_counter_param #(.WIDTH(8), .MAX_COUNT(255), .SATURATE(1'b0)) u8 (
      .clk(clk), .rst(rst), .enable(enable), .direction(direction), .load(load),
      .load_value(lv), .clear_err(clear_err), .counter_out(c8), .tc(tc_o[0]),
      .at_max(mx_o[0]), .at_min(mn_o[0]), .load_err(er_o[0]));
   updown_counter_param #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b0)) uw (
      .clk(clk), .rst(rst), .enable(enable), .direction(direction), .load(load),
      .load_value(lv[3:0]), .clear_err(clear_err), .counter_out(cw), .tc(tc_o[1]),
      .at_max(mx_o[1]), .at_min(mn_o[1]), .load_err(er_o[1]));
   updown_counter_param #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b1)) us (
      .clk(clk), .rst(rst), .enable(enable), .direction(direction), .load(load),
      .load_value(lv[3:0]), .clear_err(clear_err), .counter_out(cs), .tc(tc_o[2]),
      .at_max(mx_o[2]), .at_min(mn_o[2]), .load_err(er_o[2]));

   assign obs[0] = {c8, tc_o[0], mx_o[0], mn_o[0], er_o[0]};
   assign obs[1] = {4'b0, cw, tc_o[1], mx_o[1], mn_o[1], er_o[1]};
   assign obs[2] = {4'b0, cs, tc_o[2], mx_o[2], mn_o[2], er_o[2]};

   function automatic logic [11:0] expv(int i);
      return {8'(m_cnt[i]), m_tc[i], m_cnt[i] == mx_a[i], m_cnt[i] == 0, m_err[i]};
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 3; i++) begin
         m_cnt[i] = 0;
         m_tc[i]  = 1'b0;
         m_err[i] = 1'b0;
      end
   endfunction

   // next state from the counting rules: step, and if it leaves 0..max then wrap or hold
   function automatic void model_step();
      for (int i = 0; i < 3; i++) begin
         int v = int'(lv) & mask_a[i];
         int n;
         m_err[i] = (m_err[i] && !clear_err) || (load && v > mx_a[i]);
         m_tc[i]  = 1'b0;
         if (load) m_cnt[i] = (v > mx_a[i]) ? mx_a[i] : v;
         else if (enable) begin
            n = m_cnt[i] + (direction ? 1 : -1);
            if (n < 0 || n > mx_a[i]) begin
               m_tc[i] = 1'b1;
               n = sat_a[i] ? m_cnt[i] : (n < 0 ? mx_a[i] : 0);
            end
            m_cnt[i] = n;
         end
      end
   endfunction

   task automatic cyc(input bit ld, en, dir, clr, input logic [7:0] v);
      load = ld; enable = en; direction = dir; clear_err = clr; lv = v;
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0; enable = 1'b1; direction = 1'b1; lv = 8'($urandom);
      @(negedge clk);
      model_reset();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (obs[i] !== expv(i)) begin
            errors++;
            $display("FAIL reset inst=%0d got=%h exp=%h (cnt,tc,max,min,err)", i, obs[i], expv(i));
         end
      end
      enable = 1'b0;
      rst = 1'b1;
   endtask

   task automatic test_up_wrap();
      for (int k = 0; k < 257; k++) begin
         cyc(0, 1, 1, 0, 8'($urandom));
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs[i] !== expv(i)) begin
               errors++;
               $display("FAIL up_wrap k=%0d inst=%0d got=%h exp=%h", k, i, obs[i], expv(i));
            end
         end
      end
   endtask

   task automatic test_down_sat();
      logic [7:0] seq [14] = '{8'd2, 0, 0, 0, 0, 8'd8, 0, 0, 0, 8'd0, 0, 0, 8'd9, 0};
      bit ld [14]  = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0};
      bit dir [14] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1};
      for (int k = 0; k < 14; k++) begin
         cyc(ld[k], 1, dir[k], 0, seq[k]);
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs[i] !== expv(i)) begin
               errors++;
               $display("FAIL down_sat k=%0d inst=%0d got=%h exp=%h", k, i, obs[i], expv(i));
            end
         end
      end
   endtask

   task automatic test_load_err();
      bit ld [5]  = '{1, 0, 1, 0, 1};
      bit clr [5] = '{0, 1, 1, 1, 0};
      logic [7:0] v [5] = '{8'd12, 8'd0, 8'd12, 8'd0, 8'd3};
      for (int k = 0; k < 5; k++) begin
         cyc(ld[k], 1, 1, clr[k], v[k]);
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs[i] !== expv(i)) begin
               errors++;
               $display("FAIL load_err k=%0d inst=%0d got=%h exp=%h", k, i, obs[i], expv(i));
            end
         end
      end
   endtask

   task automatic test_gating();
      bit ld [8]  = '{1, 0, 0, 0, 0, 0, 0, 0};
      bit en [8]  = '{0, 1, 1, 0, 0, 0, 1, 1};
      bit dir [8] = '{0, 1, 1, 0, 1, 0, 0, 0};
      for (int k = 0; k < 8; k++) begin
         cyc(ld[k], en[k], dir[k], 0, 8'd5);
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs[i] !== expv(i)) begin
               errors++;
               $display("FAIL gating k=%0d inst=%0d got=%h exp=%h", k, i, obs[i], expv(i));
            end
         end
      end
   endtask

   task automatic test_async_reset();
      cyc(1, 0, 0, 0, 8'd100);
      #2 rst = 1'b0;
      #1 model_reset();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (obs[i] !== expv(i)) begin
            errors++;
            $display("FAIL async_rst inst=%0d got=%h exp=%h", i, obs[i], expv(i));
         end
      end
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc(0, 1, 1, 0, 8'd0);
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs[i] !== expv(i)) begin
               errors++;
               $display("FAIL resume k=%0d inst=%0d got=%h exp=%h", k, i, obs[i], expv(i));
            end
         end
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         cyc($urandom_range(7) == 0, $urandom_range(3) != 0, 1'($urandom),
             $urandom_range(7) == 0, 8'($urandom));
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs[i] !== expv(i)) begin
               errors++;
               $display("FAIL random k=%0d inst=%0d got=%h exp=%h", k, i, obs[i], expv(i));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_up_wrap();
      test_down_sat();
      test_load_err();
      test_gating();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
